div_unit: RTL and testbench

- Iterative radix-2 divider for the EX stage. Executes DIV/DIVU/REM/REMU in place of the single-cycle combinational divide path.
- Takes operands from the ID/EX register after forwarding, in parallel with the ALU.
- Its result is muxed with the ALU result into EX/MEM.
- Drives a stall to the hazard unit while an operation is in flight.

---
 rtl/div_if.sv | 24 ++
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Handshake and operand/result bundle between the EX stage and the iterative divider.
interface div_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU) for the EX stage.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass RUN.
module div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  div_if.slave dif
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_rem_q, is_rem_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             done_q, done_d;

  logic             accept_c, sign_op_c, sa_c, sb_c, bz_c, special_c;
  logic [XLEN-1:0]  a_abs_c, b_abs_c, quo_fix_c, rem_fix_c;
  logic [XLEN:0]    rem_sh_c, trial_c;

  assign accept_c  = (state_q == IDLE) & dif.start & ~dif.flush;
  assign sign_op_c = ~dif.op[0];
  assign sa_c      = sign_op_c & dif.a[XLEN-1];
  assign sb_c      = sign_op_c & dif.b[XLEN-1];
  assign bz_c      = (dif.b == '0);
  assign a_abs_c   = sa_c ? (XLEN'(0) - dif.a) : dif.a;
  assign b_abs_c   = sb_c ? (XLEN'(0) - dif.b) : dif.b;

`ifdef DIV_EARLY_OUT_EN
  assign special_c = bz_c | (sign_op_c & (dif.a == {1'b1, {(XLEN-1){1'b0}}}) & (dif.b == '1));
`else
  assign special_c = 1'b0;
`endif

  // One restoring step: trial is XLEN+1 wide so its MSB is the borrow.
  assign rem_sh_c  = {rem_q, quo_q[XLEN-1]};
  assign trial_c   = rem_sh_c - {1'b0, dvs_q};
  assign quo_fix_c = negq_q ? (XLEN'(0) - quo_q) : quo_q;
  assign rem_fix_c = negr_q ? (XLEN'(0) - rem_q) : rem_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = special_c ? FIX : RUN;
      RUN:     if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (dif.flush) state_d = IDLE;
  end

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          is_rem_d = dif.op[1];
          // Quotient sign fix is skipped on divide-by-zero so it stays all ones.
          negq_d   = (sa_c ^ sb_c) & ~bz_c;
          negr_d   = sa_c;
          dvs_d    = b_abs_c;
          quo_d    = a_abs_c;
          rem_d    = '0;
          cnt_d    = CNT_W'(XLEN);
          if (special_c) begin
            quo_d = bz_c ? '1 : {1'b1, {(XLEN-1){1'b0}}};
            rem_d = bz_c ? a_abs_c : '0;
          end
        end
      end
      RUN: begin
        if (!trial_c[XLEN]) begin
          rem_d = trial_c[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh_c[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
      FIX: begin
        if (!dif.flush) begin
          result_d = is_rem_q ? rem_fix_c : quo_fix_c;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      done_q   <= done_d;
    end
  end

  assign dif.busy   = (state_q != IDLE);
  assign dif.stall  = accept_c | (state_q == RUN) | (state_q == FIX);
  assign dif.done   = done_q;
  assign dif.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: reference model built on native SV division.
module tb_div_unit;
  localparam int unsigned XLEN = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  div_if #(.XLEN(XLEN)) dif ();
  div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (.clk(clk), .rst(rst), .dif(dif));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; int lat; } exp_t;
  typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; } vec_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    logic        sgn;
    sgn = ~op[0];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (EARLY && special) ? 2 : 34;
  endfunction

  // Called just after a falling edge; returns just after the falling edge of the cycle after done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold,
                        output logic [31:0] res, output int lat, output bit stall_ok, output bit pulse_ok);
    exp_t e;
    dif.start = 1'b1; dif.op = op; dif.a = a; dif.b = b;
    e.res = model(op, a, b);
    e.lat = exp_lat(op, a, b);
    sb_q.push_back(e);
    #1 stall_ok = (dif.stall === 1'b1);
    lat = -1; pulse_ok = 1'b0; res = 'x;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clk);
      if (!hold) dif.start = 1'b0;
      #1;
      if (dif.done === 1'b1) begin
        lat = c; res = dif.result;
        if (dif.stall !== 1'b0) stall_ok = 1'b0;
        dif.start = 1'b0;
      end else if (dif.stall !== 1'b1 || dif.busy !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    if (lat >= 0) begin
      @(negedge clk); #1;
      pulse_ok = (dif.done === 1'b0) && (dif.busy === 1'b0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", dif.busy); end
    checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", dif.done); end
    checks++; if (dif.result !== 32'd0) begin errors++; $display("FAIL reset result: got %h expected 0", dif.result); end
    checks++; if (dif.stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b expected 0", dif.stall); end
    rst = 1'b0;
  endtask

  task automatic test_arith;
    vec_t v[10] = '{
      '{2'b00, 32'd100, 32'd7}, '{2'b10, 32'd100, 32'd7},
      '{2'b00, 32'hFFFF_FFF9, 32'd2}, '{2'b10, 32'hFFFF_FFF9, 32'd2},
      '{2'b01, 32'hFFFF_FFFF, 32'h10}, '{2'b11, 32'hFFFF_FFFF, 32'h10},
      '{2'b00, 32'd100, 32'hFFFF_FFF9}, '{2'b10, 32'd100, 32'hFFFF_FFF9},
      '{2'b01, 32'd3, 32'd9}, '{2'b11, 32'hDEAD_BEEF, 32'h0001_2345}};
    logic [31:0] res; int lat; bit s_ok, p_ok; exp_t e;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, 1'b0, res, lat, s_ok, p_ok);
      e = sb_q.pop_front();
      checks++; if (res !== e.res) begin errors++; $display("FAIL arith[%0d] result: got %h expected %h", i, res, e.res); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL arith[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (!s_ok) begin errors++; $display("FAIL arith[%0d] stall/busy profile: got bad expected good", i); end
      checks++; if (!p_ok) begin errors++; $display("FAIL arith[%0d] done pulse width: got >1 expected 1", i); end
    end
  endtask

  task automatic test_special;
    vec_t v[8] = '{
      '{2'b00, 32'd5, 32'd0}, '{2'b10, 32'd5, 32'd0}, '{2'b01, 32'd0, 32'd0},
      '{2'b10, 32'hFFFF_FFFB, 32'd0}, '{2'b00, 32'hFFFF_FFFB, 32'd0},
      '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF}, '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF},
      '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF}};
    logic [31:0] res; int lat; bit s_ok, p_ok; exp_t e;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, 1'b0, res, lat, s_ok, p_ok);
      e = sb_q.pop_front();
      checks++; if (res !== e.res) begin errors++; $display("FAIL special[%0d] result: got %h expected %h", i, res, e.res); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL special[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (!s_ok || !p_ok) begin errors++; $display("FAIL special[%0d] handshake: got stall_ok=%0b pulse_ok=%0b expected 1/1", i, s_ok, p_ok); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] prev, res; int lat; bit s_ok, p_ok, seen; exp_t e;
    dif.start = 1'b1; dif.flush = 1'b1; dif.op = 2'b00; dif.a = 32'd77; dif.b = 32'd5;
    #1;
    checks++; if (dif.stall !== 1'b0) begin errors++; $display("FAIL flush_idle stall: got %b expected 0", dif.stall); end
    @(negedge clk); #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL flush_idle accept: got busy=%b expected 0", dif.busy); end
    dif.flush = 1'b0; dif.a = 32'd1000; dif.b = 32'd3;
    prev = dif.result; seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); #1;
      if (dif.done === 1'b1) seen = 1'b1;
      if (c == 10) dif.flush = 1'b1;
    end
    @(negedge clk); #1;
    if (dif.done === 1'b1) seen = 1'b1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL flush busy: got %b expected 0", dif.busy); end
    checks++; if (seen) begin errors++; $display("FAIL flush done: got pulse expected none"); end
    checks++; if (dif.result !== prev) begin errors++; $display("FAIL flush result: got %h expected %h", dif.result, prev); end
    dif.flush = 1'b0;
    run_op(2'b00, 32'd1000, 32'd3, 1'b1, res, lat, s_ok, p_ok);
    e = sb_q.pop_front();
    checks++; if (res !== e.res) begin errors++; $display("FAIL post_flush result: got %h expected %h", res, e.res); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL post_flush held-start latency: got %0d expected %0d", lat, e.lat); end
  endtask

  task automatic test_rst_mid;
    logic [31:0] res; int lat; bit s_ok, p_ok; exp_t e;
    dif.start = 1'b1; dif.op = 2'b01; dif.a = 32'd999; dif.b = 32'd4;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b expected 0", dif.busy); end
    checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL rst_mid done: got %b expected 0", dif.done); end
    checks++; if (dif.result !== 32'd0) begin errors++; $display("FAIL rst_mid result: got %h expected 0", dif.result); end
    checks++; if (dif.stall !== 1'b0) begin errors++; $display("FAIL rst_mid stall: got %b expected 0", dif.stall); end
    rst = 1'b0;
    @(negedge clk); #1;
    run_op(2'b11, 32'd1000, 32'd7, 1'b0, res, lat, s_ok, p_ok);
    e = sb_q.pop_front();
    checks++; if (res !== e.res) begin errors++; $display("FAIL post_rst result: got %h expected %h", res, e.res); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL post_rst latency: got %0d expected %0d", lat, e.lat); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res, a, b; logic [1:0] op; int lat; bit s_ok, p_ok; exp_t e;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 4 == 1) b = -b;
      run_op(op, a, b, 1'b0, res, lat, s_ok, p_ok);
      e = sb_q.pop_front();
      checks++; if (res !== e.res) begin errors++; $display("FAIL b2b[%0d] op=%0d a=%h b=%h result: got %h expected %h", i, op, a, b, res, e.res); end
      checks++; if (lat != e.lat || !s_ok || !p_ok) begin errors++; $display("FAIL b2b[%0d] timing: got lat=%0d stall_ok=%0b pulse_ok=%0b expected lat=%0d 1/1", i, lat, s_ok, p_ok, e.lat); end
    end
  endtask

  initial begin
    rst = 1'b1; dif.start = 1'b0; dif.flush = 1'b0; dif.op = 2'b00; dif.a = '0; dif.b = '0;
    test_reset();
    @(negedge clk); #1;
    test_arith();
    test_special();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
